hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1: cycles of bubble inserted per load-use hazard, legal range 1..7.
REQ-002 SHALL have parameter HALT_CODE, default 32'd10: $v0 value that makes a syscall halt the core.
REQ-003 SHALL have clock and reset ports `clk  in  1  rising-edge clock` and `rst_n  in  1  asynchronous active-low reset`.
REQ-004 SHALL have `rs_id  in  5  source register 1 of the instruction in ID` and `rt_id  in  5  source register 2 of the instruction in ID`.
REQ-005 SHALL have `use_rs_id  in  1  ID reads rs` and `use_rt_id  in  1  ID reads rt`.
REQ-006 SHALL have `MemRead_id_ex  in  1  EX holds a load` and `RegWrite_id_ex  in  1  EX writes a register`.
REQ-007 SHALL have `regfile_write_num_id_ex  in  5  EX destination register`.
REQ-008 SHALL have `branch_taken_ex  in  1  EX resolved a taken branch or jump`.
REQ-009 SHALL have `syscall_ex  in  1  EX holds a syscall` and `v0_ex  in  32  forwarded $v0 value`.
REQ-010 SHALL have `pc_hold  out  1  freeze PC and IF/ID` and `nop_lock_id  out  1  bubble ID/EX for a stall`.
REQ-011 SHALL have `pc_bj  out  1  flush IF/ID and ID/EX` and `halt_ex  out  1  force the halt syscall into ID/EX`.
REQ-012 SHALL have `halted  out  1  core stopped` and `stall_cnt, flush_cnt, cycle_cnt  out  32 each  performance counters`.

Function
REQ-013 SHALL implement FSM states RUN, STALL, HALTED, held in a state register.
REQ-014 SHALL compute hazard = MemRead_id_ex & RegWrite_id_ex & (regfile_write_num_id_ex != 0) & ((use_rs_id & rs_id == regfile_write_num_id_ex) | (use_rt_id & rt_id == regfile_write_num_id_ex)).
REQ-015 SHALL compute halt_req = syscall_ex & (v0_ex == HALT_CODE).
REQ-016 SHALL apply the RUN priority halt_req > branch_taken_ex > hazard.
REQ-017 In RUN with halt_req, SHALL drive halt_ex=1 and pc_hold=1 combinationally and enter HALTED next edge.
REQ-018 In RUN with branch_taken_ex and no halt_req, SHALL drive pc_bj=1 for that cycle only and stay in RUN; a concurrent hazard is discarded.
REQ-019 In RUN with hazard only, SHALL drive pc_hold=1 and nop_lock_id=1 combinationally.
REQ-020 On a RUN hazard with LOAD_LAT>1, SHALL enter STALL with the 3-bit counter loaded to LOAD_LAT-1; with LOAD_LAT=1 it SHALL stay in RUN.
REQ-021 In STALL, SHALL hold pc_hold=1 and nop_lock_id=1 and decrement the counter, returning to RUN when the counter is 1 at a clock edge, so the total bubble is exactly LOAD_LAT cycles.
REQ-022 In STALL, branch_taken_ex SHALL be ignored (EX holds a bubble), while halt_req SHALL still take priority and enter HALTED.
REQ-023 In HALTED, SHALL hold halt_ex=1, pc_hold=1 and halted=1, with pc_bj=0 and nop_lock_id=0; HALTED is left only by reset.
REQ-024 SHALL increment stall_cnt in every cycle nop_lock_id=1, flush_cnt in every cycle pc_bj=1, and cycle_cnt in every cycle not HALTED.
REQ-025 All counters SHALL saturate at 32'hFFFFFFFF.
REQ-026 halted SHALL be registered (state==HALTED); all other outputs SHALL be combinational from state, counter and inputs.

Reset
REQ-027 rst_n low SHALL immediately set state=RUN, stall counter=0 and all performance counters=0.
REQ-028 During reset, all outputs SHALL read 0 and the hazard/branch/halt inputs SHALL be ignored.
REQ-029 Reset asserted mid-STALL or in HALTED SHALL abort the operation; the first edge after release begins in RUN.

Structure
REQ-030 The state enum (RUN/STALL/HALTED), the HALT_CODE default and the register-number width SHALL live in shared package cpu_pkg.
REQ-031 Hazard detection SHALL be a sub-module, load_use_detect (combinational comparator), instantiated once.

Verification
REQ-032 Load r8 in EX with rs_id=8 and use_rs_id=1, LOAD_LAT=1 -> pc_hold and nop_lock_id high for 1 cycle, stall_cnt=1.
REQ-033 The same hazard with LOAD_LAT=3 -> 3 consecutive bubble cycles, then RUN; stall_cnt=3.
REQ-034 Destination register 0, or use_rs_id=0 with rs matching -> no stall.
REQ-035 branch_taken_ex and hazard in the same cycle -> pc_bj=1, nop_lock_id=0, flush_cnt=1, state stays RUN.
REQ-036 syscall_ex with v0_ex=10 -> halt_ex=1 that cycle, halted=1 next cycle, cycle_cnt frozen.
REQ-037 syscall_ex with v0_ex=4 -> no halt.
REQ-038 Pulse rst_n low while HALTED -> all outputs 0 and counters 0 immediately; normal flow resumes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM states, register-number width and the
// default halt syscall code, plus a saturating counter helper.
package cpu_pkg;

  localparam int          REG_W         = 5;
  localparam logic [31:0] HALT_CODE_DEF = 32'd10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    logic [31:0] res;
    if (en && (val != 32'hFFFF_FFFF)) begin
      res = val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID-stage source that depends on a load
// currently in EX.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic             MemRead_id_ex,
  input  logic             RegWrite_id_ex,
  input  logic [REG_W-1:0] regfile_write_num_id_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  output logic             hazard
);

  logic rs_match_s;
  logic rt_match_s;
  logic dest_live_s;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  always_comb begin
    dest_live_s = MemRead_id_ex & RegWrite_id_ex & (regfile_write_num_id_ex != 5'd0);
    rs_match_s  = use_rs_id & (rs_id == regfile_write_num_id_ex);
    rt_match_s  = use_rt_id & (rt_id == regfile_write_num_id_ex);
    hazard      = dest_live_s & (rs_match_s | rt_match_s);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, halt syscall
// handling and saturating performance counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int          LOAD_LAT  = 1,
  parameter logic [31:0] HALT_CODE = HALT_CODE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             MemRead_id_ex,
  input  logic             RegWrite_id_ex,
  input  logic [REG_W-1:0] regfile_write_num_id_ex,
  input  logic             branch_taken_ex,
  input  logic             syscall_ex,
  input  logic [31:0]      v0_ex,
  output logic             pc_hold,
  output logic             nop_lock_id,
  output logic             pc_bj,
  output logic             halt_ex,
  output logic             halted,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [31:0]      cycle_cnt
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  hz_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] cycle_q, cycle_d;

  logic hazard_s;
  logic halt_req_s;
  logic pc_hold_s, nop_s, pc_bj_s, halt_ex_s;

  load_use_detect u_detect (
    .MemRead_id_ex           (MemRead_id_ex),
    .RegWrite_id_ex          (RegWrite_id_ex),
    .regfile_write_num_id_ex (regfile_write_num_id_ex),
    .rs_id                   (rs_id),
    .rt_id                   (rt_id),
    .use_rs_id               (use_rs_id),
    .use_rt_id               (use_rt_id),
    .hazard                  (hazard_s)
  );

  // Next-state and combinational control outputs; halt beats branch beats hazard.
  always_comb begin
    halt_req_s = syscall_ex & (v0_ex == HALT_CODE);
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_hold_s  = 1'b0;
    nop_s      = 1'b0;
    pc_bj_s    = 1'b0;
    halt_ex_s  = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req_s) begin
          halt_ex_s = 1'b1;
          pc_hold_s = 1'b1;
          state_d   = HALTED;
          cnt_d     = 3'd0;
        end else if (branch_taken_ex) begin
          pc_bj_s = 1'b1;
        end else if (hazard_s) begin
          pc_hold_s = 1'b1;
          nop_s     = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = LAT_M1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      // EX only holds a bubble here, so a branch indication cannot be genuine.
      STALL: begin
        if (halt_req_s) begin
          halt_ex_s = 1'b1;
          pc_hold_s = 1'b1;
          state_d   = HALTED;
          cnt_d     = 3'd0;
        end else begin
          pc_hold_s = 1'b1;
          nop_s     = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      HALTED: begin
        halt_ex_s = 1'b1;
        pc_hold_s = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
    halted_d = (state_d == HALTED);
    stall_d  = sat_inc(stall_q, nop_s);
    flush_d  = sat_inc(flush_q, pc_bj_s);
    cycle_d  = sat_inc(cycle_q, state_q != HALTED);
  end

  // State, bubble counter and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      halted_q <= 1'b0;
      stall_q  <= 32'd0;
      flush_q  <= 32'd0;
      cycle_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      cycle_q  <= cycle_d;
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign pc_hold     = rst_n & pc_hold_s;
  assign nop_lock_id = rst_n & nop_s;
  assign pc_bj       = rst_n & pc_bj_s;
  assign halt_ex     = rst_n & halt_ex_s;
  assign halted      = halted_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign cycle_cnt   = cycle_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and
// are checked every cycle against a bubble-count model plus literal counter values.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_id, rt_id, wn;
  logic        use_rs_id, use_rt_id, mem_rd, reg_wr, br, sc;
  logic [31:0] v0;

  logic [1:0]  ph_o, nl_o, bj_o, hx_o, hd_o;
  logic [31:0] stall_o [2];
  logic [31:0] flush_o [2];
  logic [31:0] cycle_o [2];

  int total = 0;
  int bad   = 0;

  int          lat_m    [2] = '{1, 3};
  logic        m_halted [2];
  int          m_left   [2];
  logic [31:0] m_stall  [2];
  logic [31:0] m_flush  [2];
  logic [31:0] m_cycle  [2];

  hazard_ctrl #(.LOAD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .MemRead_id_ex(mem_rd), .RegWrite_id_ex(reg_wr), .regfile_write_num_id_ex(wn),
    .branch_taken_ex(br), .syscall_ex(sc), .v0_ex(v0),
    .pc_hold(ph_o[0]), .nop_lock_id(nl_o[0]), .pc_bj(bj_o[0]), .halt_ex(hx_o[0]),
    .halted(hd_o[0]), .stall_cnt(stall_o[0]), .flush_cnt(flush_o[0]), .cycle_cnt(cycle_o[0])
  );

  hazard_ctrl #(.LOAD_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .MemRead_id_ex(mem_rd), .RegWrite_id_ex(reg_wr), .regfile_write_num_id_ex(wn),
    .branch_taken_ex(br), .syscall_ex(sc), .v0_ex(v0),
    .pc_hold(ph_o[1]), .nop_lock_id(nl_o[1]), .pc_bj(bj_o[1]), .halt_ex(hx_o[1]),
    .halted(hd_o[1]), .stall_cnt(stall_o[1]), .flush_cnt(flush_o[1]), .cycle_cnt(cycle_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit hz_now();
    return mem_rd && reg_wr && (wn != 5'd0) &&
           ((use_rs_id && rs_id == wn) || (use_rt_id && rt_id == wn));
  endfunction

  function automatic bit halt_now();
    return sc && (v0 == 32'd10);
  endfunction

  // Model: a core is either halted, owes some bubble cycles, or is free to act.
  function automatic void exp_outs(input int k, output logic ph, output logic nl,
                                   output logic bj, output logic hx);
    ph = 1'b0; nl = 1'b0; bj = 1'b0; hx = 1'b0;
    if (rst_n !== 1'b1) return;
    if (m_halted[k] || halt_now()) begin
      ph = 1'b1; hx = 1'b1;
    end else if (m_left[k] > 0) begin
      ph = 1'b1; nl = 1'b1;
    end else if (br) begin
      bj = 1'b1;
    end else if (hz_now()) begin
      ph = 1'b1; nl = 1'b1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_halted[k] <= 1'b0; m_left[k] <= 0;
        m_stall[k] <= 32'd0; m_flush[k] <= 32'd0; m_cycle[k] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic ph, nl, bj, hx;
        exp_outs(k, ph, nl, bj, hx);
        m_stall[k] <= m_stall[k] + {31'd0, nl};
        m_flush[k] <= m_flush[k] + {31'd0, bj};
        if (!m_halted[k]) begin
          m_cycle[k] <= m_cycle[k] + 32'd1;
          if (halt_now()) begin
            m_halted[k] <= 1'b1; m_left[k] <= 0;
          end else if (m_left[k] > 0) begin
            m_left[k] <= m_left[k] - 1;
          end else if (hz_now() && !br) begin
            m_left[k] <= lat_m[k] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic ph, nl, bj, hx;
      exp_outs(k, ph, nl, bj, hx);
      chk($sformatf("pc_hold[%0d]", k),     {31'd0, ph_o[k]}, {31'd0, ph});
      chk($sformatf("nop_lock_id[%0d]", k), {31'd0, nl_o[k]}, {31'd0, nl});
      chk($sformatf("pc_bj[%0d]", k),       {31'd0, bj_o[k]}, {31'd0, bj});
      chk($sformatf("halt_ex[%0d]", k),     {31'd0, hx_o[k]}, {31'd0, hx});
      chk($sformatf("halted[%0d]", k),      {31'd0, hd_o[k]}, {31'd0, m_halted[k]});
      chk($sformatf("stall_cnt[%0d]", k),   stall_o[k], m_stall[k]);
      chk($sformatf("flush_cnt[%0d]", k),   flush_o[k], m_flush[k]);
      chk($sformatf("cycle_cnt[%0d]", k),   cycle_o[k], m_cycle[k]);
    end
  end

  task automatic step(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_urs,
                      input logic a_urt, input logic a_mr, input logic a_rw,
                      input logic [4:0] a_wn, input logic a_br, input logic a_sc,
                      input logic [31:0] a_v0);
    rs_id = a_rs; rt_id = a_rt; use_rs_id = a_urs; use_rt_id = a_urt;
    mem_rd = a_mr; reg_wr = a_rw; wn = a_wn; br = a_br; sc = a_sc; v0 = a_v0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic load_r8();
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic lit2(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1);
    chk({nm, "_lat1"}, a0, e0);
    chk({nm, "_lat3"}, a1, e1);
  endtask

  initial begin
    rst_n = 1'b0;
    // hazard, branch and halt all asserted while reset is held
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 32'd10);
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 32'd10);
    lit2("reset_halted", {31'd0, hd_o[0]}, {31'd0, hd_o[1]}, 32'd0, 32'd0);
    rst_n = 1'b1;
    idle(2);
    lit2("cycle_after_release", cycle_o[0], cycle_o[1], 32'd2, 32'd2);

    load_r8(); idle(4);
    lit2("stall_rs_hazard", stall_o[0], stall_o[1], 32'd1, 32'd3);

    step(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 32'd0); idle(4);
    lit2("stall_rt_hazard", stall_o[0], stall_o[1], 32'd2, 32'd6);

    step(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'd0);
    step(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 32'd0);
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 32'd0);
    idle(1);
    lit2("no_stall_cases", stall_o[0], stall_o[1], 32'd2, 32'd6);

    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'd0); idle(1);
    lit2("flush_branch_hazard", flush_o[0], flush_o[1], 32'd1, 32'd1);
    lit2("stall_branch_hazard", stall_o[0], stall_o[1], 32'd2, 32'd6);

    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0); idle(1);
    lit2("flush_branch_only", flush_o[0], flush_o[1], 32'd2, 32'd2);

    load_r8();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0);
    idle(3);
    lit2("flush_branch_in_stall", flush_o[0], flush_o[1], 32'd3, 32'd2);
    lit2("stall_branch_in_stall", stall_o[0], stall_o[1], 32'd3, 32'd9);

    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'd4); idle(1);
    lit2("no_halt_v0_4", {31'd0, hd_o[0]}, {31'd0, hd_o[1]}, 32'd0, 32'd0);

    load_r8();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'd10);
    for (int i = 0; i < 3; i++)
      step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'd0);
    lit2("halted_set", {31'd0, hd_o[0]}, {31'd0, hd_o[1]}, 32'd1, 32'd1);
    lit2("stall_at_halt", stall_o[0], stall_o[1], 32'd4, 32'd10);
    lit2("flush_at_halt", flush_o[0], flush_o[1], 32'd3, 32'd2);

    rst_n = 1'b0;
    idle(1);
    lit2("reset_in_halt_stall", stall_o[0], stall_o[1], 32'd0, 32'd0);
    lit2("reset_in_halt_cycle", cycle_o[0], cycle_o[1], 32'd0, 32'd0);
    lit2("reset_in_halt_halted", {31'd0, hd_o[0]}, {31'd0, hd_o[1]}, 32'd0, 32'd0);
    rst_n = 1'b1;
    load_r8(); idle(3);
    lit2("resume_stall", stall_o[0], stall_o[1], 32'd1, 32'd3);
    lit2("resume_cycle", cycle_o[0], cycle_o[1], 32'd4, 32'd4);

    load_r8();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    lit2("reset_mid_stall", stall_o[0], stall_o[1], 32'd0, 32'd0);
    lit2("reset_mid_stall_hold", {31'd0, ph_o[0]}, {31'd0, ph_o[1]}, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
